// File: rtl/bus_oe_arbiter.sv
// ---------------------------------------------------------------------------
// bus_oe_arbiter
//
// Round-robin arbiter that shares one tri-state / OE-muxed bus among N
// requesters. It drives the select and output-enable of the bus mux/buffer
// bank. Every change of owner passes through a dead window of TURN_CYC
// cycles with oe=0 and a stable select, so two drivers are never enabled
// together.
//
// Optional feature (macro HOLD_LIMIT_EN):
//   When defined, an owner that has held the bus for MAX_HOLD consecutive
//   cycles while someone else is waiting is forced off the bus. When
//   undefined, an owner keeps the bus for as long as its req stays high.
//
// Parameters:
//   N         number of requesters (2..16)
//   TURN_CYC  dead cycles with oe=0 before each new owner (>=1)
//   MAX_HOLD  max consecutive owned cycles when others wait (>=1)
//   SW        select width, $clog2(N)
//
// Ports:
//   clk   in   clock, all state changes on the rising edge
//   rst   in   synchronous active-high reset
//   req   in   [N]  request per requester, held while using the bus
//   gnt   out  [N]  one-hot grant, high only while that requester owns the bus
//   sel   out  [SW] mux select (index of current / upcoming owner)
//   oe    out  bus output enable to the buffer bank
//   busy  out  high during turnaround or ownership
//
// All outputs come straight from flops; there is no combinational path
// from req to any output.
// ---------------------------------------------------------------------------
module bus_oe_arbiter #(
  parameter int N        = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8,
  localparam int SW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] sel,
  output logic          oe,
  output logic          busy
);

  // Turnaround counter only needs to reach TURN_CYC-1.
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    OWN
  } state_t;

  state_t        state_reg;
  logic [SW-1:0] sel_reg;
  logic [SW-1:0] ptr_reg;
  logic [N-1:0]  gnt_reg;
  logic          oe_reg;
  logic          busy_reg;
  logic [TW-1:0] turn_cnt_reg;

  logic [SW-1:0] sel_inc;
  logic [SW-1:0] scan_start;
  logic [SW-1:0] win_idx;
  logic          win_found;
  logic [N-1:0]  sel_onehot;
  logic          turn_done;
  logic          leave_own;

  // One-hot decode of the current select; used both as the grant vector
  // and to mask the owner out of the "someone else waiting" test.
  for (genvar gi = 0; gi < N; gi++) begin : g_sel_dec
    assign sel_onehot[gi] = (sel_reg == SW'(gi));
  end

  // sel+1 with wrap at N-1 (N need not be a power of two).
  always_comb begin
    sel_inc = (sel_reg == SW'(N - 1)) ? '0 : sel_reg + SW'(1);
  end

  // Round-robin scan. While owning, the only arbitration that matters is the
  // one done on the leaving edge, and it must start just past the owner
  // (the pointer is updated on that same edge), so the start is sel+1 there.
  always_comb begin : p_winner
    int            j;
    logic [SW-1:0] idx;
    j          = 0;
    idx        = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    scan_start = (state_reg == OWN) ? sel_inc : ptr_reg;
    // Scan from the farthest offset down so the nearest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(scan_start) + i;
      if (j >= N) begin
        j = j - N;
      end
      idx = SW'(j);
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign turn_done = (turn_cnt_reg == TW'(TURN_CYC - 1));

`ifdef HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt_reg;
  logic          hold_hit;
  logic          others_pend;

  assign others_pend = |(req & ~sel_onehot);
  assign hold_hit    = (hold_cnt_reg == HW'(MAX_HOLD));

  // Eviction is only possible with another requester pending, which also
  // guarantees the scan finds a winner other than the evicted owner.
  assign leave_own = ~req[sel_reg] | (hold_hit & others_pend);

  // Count of owned cycles including the current one; saturates at MAX_HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_reg <= '0;
    end else if (state_reg == TURN && turn_done && req[sel_reg]) begin
      hold_cnt_reg <= HW'(1);
    end else if (state_reg == OWN && !leave_own && !hold_hit) begin
      hold_cnt_reg <= hold_cnt_reg + HW'(1);
    end
  end
`else
  assign leave_own = ~req[sel_reg];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      oe_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      turn_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // sel keeps its last value while idle; the bus is undriven.
          if (win_found) begin
            sel_reg      <= win_idx;
            turn_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= TURN;
          end
        end

        TURN: begin
          if (!turn_done) begin
            turn_cnt_reg <= turn_cnt_reg + TW'(1);
          end else if (req[sel_reg]) begin
            gnt_reg   <= sel_onehot;
            oe_reg    <= 1'b1;
            state_reg <= OWN;
          end else if (win_found) begin
            // Chosen requester gave up during turnaround: pick again and
            // give the new select its own full dead window.
            sel_reg      <= win_idx;
            turn_cnt_reg <= '0;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        OWN: begin
          if (leave_own) begin
            gnt_reg <= '0;
            oe_reg  <= 1'b0;
            ptr_reg <= sel_inc;
            if (win_found) begin
              sel_reg      <= win_idx;
              turn_cnt_reg <= '0;
              state_reg    <= TURN;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          gnt_reg   <= '0;
          oe_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign oe   = oe_reg;
  assign busy = busy_reg;

endmodule
